// File: rtl/covuniq_pkg.sv
// Shared widths, command encodings and arbiter state type
// for the dut slave command-port arbiter.
package covuniq_pkg;

    localparam int CMD_W  = 2;
    localparam int ADR_W  = 4;
    localparam int DATA_W = 3;

    localparam logic [CMD_W-1:0] CMD_NOP = '0;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/dut_rr_pick.sv
// Combinational round-robin picker: first set request bit
// searching upward from ptr+1, wrapping around.
module dut_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   index,
    output logic            any
);

    logic [IW-1:0] j;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        j      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[j]) begin
                any       = 1'b1;
                index     = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dut_slave_arbiter.sv
// Round-robin arbiter sharing the dut slave command port between
// NREQ requesters, forwarding one registered beat per handshake.
module dut_slave_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8,
    parameter int CMD_W     = covuniq_pkg::CMD_W,
    parameter int ADR_W     = covuniq_pkg::ADR_W,
    parameter int DATA_W    = covuniq_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*CMD_W-1:0]  req_cmd,
    input  logic [NREQ*ADR_W-1:0]  req_adr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CMD_W-1:0]       m_cmd,
    output logic [ADR_W-1:0]       m_adr,
    output logic [DATA_W-1:0]      m_data,
    output logic [$clog2(NREQ)-1:0] m_src
);

    import covuniq_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     own_q, own_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              mv_q, mv_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     src_q, src_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    dut_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req_valid),
        .ptr    (rr_q),
        .onehot (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    logic              busy, vld_g, rdy_g, acc, rel;
    logic [CMD_W-1:0]  cmd_g;

    assign busy  = (state_q == ARB_BUSY);
    assign vld_g = busy & req_valid[own_q];
    assign rdy_g = ~mv_q | m_ready;
    assign acc   = vld_g & rdy_g;
    assign cmd_g = req_cmd[own_q*CMD_W +: CMD_W];

    // A NOP still counts toward the burst; forced release on timeout
    assign rel = (acc & (req_last[own_q] | (beat_q == BW'(MAX_BURST - 1))))
               | (busy & ~vld_g & (idle_q == TW'(TIMEOUT - 1)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        mv_d    = mv_q;
        cmd_d   = cmd_q;
        adr_d   = adr_q;
        data_d  = data_q;
        src_d   = src_q;
        if (acc) begin
            cmd_d  = cmd_g;
            adr_d  = req_adr[own_q*ADR_W +: ADR_W];
            data_d = req_data[own_q*DATA_W +: DATA_W];
            src_d  = own_q;
            mv_d   = (cmd_g != CMD_W'(CMD_NOP));
            beat_d = beat_q + 1'b1;
        end else if (m_ready) begin
            mv_d = 1'b0;
        end
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_oh;
                    own_d   = pick_idx;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            ARB_BUSY: begin
                idle_d = vld_g ? '0 : idle_q + 1'b1;
                if (rel) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    rr_d    = own_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            own_q   <= '0;
            rr_q    <= IW'(NREQ - 1);
            beat_q  <= '0;
            idle_q  <= '0;
            mv_q    <= 1'b0;
            cmd_q   <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
            mv_q    <= mv_d;
            cmd_q   <= cmd_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign req_ready = grant_q & {NREQ{rdy_g}};
    assign grant     = grant_q;
    assign m_valid   = mv_q;
    assign m_cmd     = cmd_q;
    assign m_adr     = adr_q;
    assign m_data    = data_q;
    assign m_src     = src_q;

endmodule

// File: tb/tb_dut_slave_arbiter.sv
// Directed bench for dut_slave_arbiter: vector table for a simple
// burst plus hand-written multi-cycle sequences.
module tb_dut_slave_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_last, grant;
    logic [7:0]  req_cmd;
    logic [15:0] req_adr;
    logic [11:0] req_data;
    logic        m_valid, m_ready;
    logic [1:0]  m_cmd;
    logic [3:0]  m_adr;
    logic [2:0]  m_data;
    logic [1:0]  m_src;

    int passed = 0;
    int total  = 0;
    int beats[4];
    logic [3:0] xfer[$];

    always #5 clk = ~clk;

    dut_slave_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_cmd(req_cmd), .req_adr(req_adr), .req_data(req_data),
        .grant(grant), .m_valid(m_valid), .m_ready(m_ready),
        .m_cmd(m_cmd), .m_adr(m_adr), .m_data(m_data), .m_src(m_src)
    );

    typedef struct {
        logic       vld;
        logic       last;
        logic [3:0] adr;
        logic       mrdy;
        logic [3:0] e_grant;
        logic       e_mv;
        logic [3:0] e_adr;
        logic [3:0] e_rdy;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic set_beat(input int i, input logic [1:0] c,
                            input logic [3:0] a, input logic [2:0] d);
        req_cmd[i*2 +: 2]  = c;
        req_adr[i*4 +: 4]  = a;
        req_data[i*3 +: 3] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_cmd   = '0;
        req_adr   = '0;
        req_data  = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic capture();
        if (m_valid && m_ready) xfer.push_back(m_adr);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'd5, 1'b1, 4'h0, 1'b0, 4'd0, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 4'd5, 1'b1, 4'h1, 1'b0, 4'd0, 4'h1};
        tbl[2] = '{1'b1, 1'b0, 4'd6, 1'b1, 4'h1, 1'b1, 4'd5, 4'h1};
        tbl[3] = '{1'b1, 1'b1, 4'd7, 1'b1, 4'h1, 1'b1, 4'd6, 4'h1};
        tbl[4] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'h0, 1'b1, 4'd7, 4'h0};
        tbl[5] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'h0, 1'b0, 4'd0, 4'h0};

        // reset state
        do_reset();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_madr", m_adr, 0);
        chk("rst_msrc", m_src, 0);

        // single requester burst from table
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            req_valid = {3'b000, tbl[c].vld};
            req_last  = {3'b000, tbl[c].last};
            set_beat(0, 2'd3, tbl[c].adr, 3'd1);
            m_ready = tbl[c].mrdy;
            #1;
            chk($sformatf("t1_grant_c%0d", c), grant, tbl[c].e_grant);
            chk($sformatf("t1_mvalid_c%0d", c), m_valid, tbl[c].e_mv);
            chk($sformatf("t1_ready_c%0d", c), req_ready, tbl[c].e_rdy);
            if (tbl[c].e_mv) begin
                chk($sformatf("t1_madr_c%0d", c), m_adr, tbl[c].e_adr);
                chk($sformatf("t1_msrc_c%0d", c), m_src, 0);
            end
        end

        // all four requesters, never last: 4-beat bursts in rr order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_beat(i, 2'd3, 4'(i), 3'(i));
            beats[i] = 0;
        end
        for (int c = 0; c < 22; c++) begin
            if (c > 0) next_cycle();
            req_valid = 4'hf;
            #1;
            chk($sformatf("t2_grant_c%0d", c), grant,
                (c % 5 == 0) ? 0 : (1 << ((c / 5) % 4)));
            if (c <= 20 && m_valid) begin
                beats[m_src]++;
                chk($sformatf("t2_adr_src_c%0d", c), m_adr, m_src);
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_beats_r%0d", i), beats[i], 4);

        // backpressure stall with held beat
        do_reset();
        xfer.delete();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next_cycle();
            req_valid = (c <= 8) ? 4'h1 : 4'h0;
            req_last  = (c == 8) ? 4'h1 : 4'h0;
            m_ready   = !(c >= 2 && c <= 6);
            if (c <= 1) set_beat(0, 2'd3, 4'd9, 3'd7);
            else if (c <= 7) set_beat(0, 2'd3, 4'd10, 3'd1);
            else set_beat(0, 2'd3, 4'd11, 3'd2);
            #1;
            capture();
            if (c >= 2 && c <= 6) begin
                chk($sformatf("t3_mvalid_c%0d", c), m_valid, 1);
                chk($sformatf("t3_madr_c%0d", c), m_adr, 9);
                chk($sformatf("t3_mdata_c%0d", c), m_data, 7);
                chk($sformatf("t3_ready_c%0d", c), req_ready, 0);
            end
        end
        chk("t3_xfer_count", xfer.size(), 3);
        if (xfer.size() == 3) begin
            chk("t3_xfer0", xfer[0], 9);
            chk("t3_xfer1", xfer[1], 10);
            chk("t3_xfer2", xfer[2], 11);
        end

        // r2 goes idle after grant: timeout, then r3 beats r0
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next_cycle();
            req_valid = (c == 0) ? 4'b0100 : 4'b1001;
            #1;
            if (c >= 1 && c <= 8)
                chk($sformatf("t4_grant_c%0d", c), grant, 4'b0100);
        end
        chk("t4_after_release", grant, 4'b1000);
        chk("t4_no_beat", m_valid, 0);

        // NOP consumed, not forwarded, counted toward the burst
        do_reset();
        xfer.delete();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            req_valid = (c <= 4) ? 4'h1 : 4'h0;
            if (c <= 1) set_beat(0, 2'd3, 4'd1, 3'd0);
            else if (c == 2) set_beat(0, 2'd0, 4'd2, 3'd0);
            else set_beat(0, 2'd3, 4'(c), 3'd0);
            #1;
            capture();
            if (c == 3) chk("t5_nop_hidden", m_valid, 0);
            if (c == 5) chk("t5_release", grant, 0);
        end
        chk("t5_xfer_count", xfer.size(), 3);
        if (xfer.size() == 3) begin
            chk("t5_xfer0", xfer[0], 1);
            chk("t5_xfer1", xfer[1], 3);
            chk("t5_xfer2", xfer[2], 4);
        end

        // async reset mid-burst
        do_reset();
        set_beat(2, 2'd3, 4'd8, 3'd3);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            req_valid = 4'b0100;
            #1;
        end
        chk("t6_pre_mvalid", m_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_mvalid", m_valid, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ready", req_ready, 0);
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b0111;
        #1;
        chk("t6_idle_grant", grant, 0);
        next_cycle();
        #1;
        chk("t6_first_r0", grant, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
